divider_rv32m: RTL and testbench

- Sequential restoring divider for the RV32M accelerator. It executes DIV, DIVU, REM and REMU.
- It is the inverse-direction companion of the multiplier control path in the same accelerator.
- It sits beside the multiplier behind the core's M-extension issue logic and returns one XLEN-bit result per request.
- It uses a start/busy/done handshake and produces one quotient bit per cycle.

---
 rtl/divider_rv32m_pkg.sv | 22 ++
 rtl/divider_rv32m_cp.sv | 72 +++++++
 rtl/divider_rv32m.sv | 149 ++++++++++++++
 tb/tb_divider_rv32m.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/divider_rv32m_pkg.sv
// Shared RV32M divider definitions: op encodings, divider state encoding, width default and result constants.
// State encoding is Gray-ordered along IDLE->CALC->FIX->DONE->IDLE so each transition flips one bit.
package rv32m_pkg;

    localparam int XLEN_DEF = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b11,
        DONE = 2'b10
    } div_state_t;

    localparam logic [XLEN_DEF-1:0] DIV_ZERO_Q = {XLEN_DEF{1'b1}};
    localparam logic [XLEN_DEF-1:0] SIGNED_MIN = {1'b1, {(XLEN_DEF-1){1'b0}}};

endpackage

// File: rtl/divider_rv32m_cp.sv
// Divider control path: FSM, iteration counter, registered busy/done, and the IDLE short-cut to DONE.
// A request is accepted only in IDLE; short_i (special case or reuse hit) skips CALC/FIX entirely.
module divider_cp
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    input  logic short_i,
    output logic load_o,
    output logic calc_o,
    output logic fix_o,
    output logic busy_o,
    output logic done_o
);

    localparam int CW = $clog2(XLEN);

    div_state_t    state_q;
    logic [CW-1:0] cnt_q;
    logic          busy_q;
    logic          done_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (short_i) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(XLEN - 1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign load_o = (state_q == IDLE) && start_i;
    assign calc_o = (state_q == CALC);
    assign fix_o  = (state_q == FIX);
    assign busy_o = busy_q;
    assign done_o = done_q;

endmodule

// File: rtl/divider_rv32m.sv
// RV32M restoring divider (DIV/DIVU/REM/REMU), one quotient bit per cycle, start/busy/done handshake.
// Optional DIV_RESULT_REUSE_EN keeps the last operands/results so a repeated request completes in one cycle.
module divider_rv32m
    import rv32m_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam logic [XLEN-1:0] SMIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ONES  = {XLEN{1'b1}};

    logic [XLEN-1:0] r_q, q_q, b_q, res_q;
    logic            op1_q, neg_a_q, neg_b_q;
    logic            load, calc, fix, short_req;

    // Operand conditioning for the start cycle
    logic            sgn, neg_a, neg_b, div0, ovf, hit;
    logic [XLEN-1:0] abs_a, abs_b, spec_q, spec_r, short_res, hit_res;

    assign sgn   = ~op_i[0];
    assign neg_a = sgn & a_i[XLEN-1];
    assign neg_b = sgn & b_i[XLEN-1];
    assign abs_a = neg_a ? (~a_i + 1'b1) : a_i;
    assign abs_b = neg_b ? (~b_i + 1'b1) : b_i;
    assign div0  = (b_i == '0);
    assign ovf   = sgn && (a_i == SMIN) && (b_i == ONES);

    // Remainder of a divide-by-zero is the raw dividend, never sign-corrected
    assign spec_q = div0 ? ONES : SMIN;
    assign spec_r = div0 ? a_i  : '0;

    always_comb begin
        short_res = hit_res;
        if (div0 || ovf) begin
            short_res = op_i[1] ? spec_r : spec_q;
        end
    end

    assign short_req = div0 | ovf | hit;

    // One restoring step: R stays below B, so the difference fits in XLEN bits
    logic [XLEN:0]   t;
    logic            ge;
    logic [XLEN-1:0] diff, fix_q, fix_r;

    assign t     = {r_q, q_q[XLEN-1]};
    assign ge    = (t >= {1'b0, b_q});
    assign diff  = t[XLEN-1:0] - b_q;
    assign fix_q = (neg_a_q ^ neg_b_q) ? (~q_q + 1'b1) : q_q;
    assign fix_r = neg_a_q ? (~r_q + 1'b1) : r_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_q     <= '0;
            q_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            op1_q   <= 1'b0;
            neg_a_q <= 1'b0;
            neg_b_q <= 1'b0;
        end else if (load) begin
            op1_q   <= op_i[1];
            neg_a_q <= neg_a;
            neg_b_q <= neg_b;
            q_q     <= abs_a;
            b_q     <= abs_b;
            r_q     <= '0;
            if (short_req) begin
                res_q <= short_res;
            end
        end else if (calc) begin
            r_q <= ge ? diff : t[XLEN-1:0];
            q_q <= {q_q[XLEN-2:0], ge};
        end else if (fix) begin
            res_q <= op1_q ? fix_r : fix_q;
        end
    end

`ifdef DIV_RESULT_REUSE_EN
    logic [XLEN-1:0] raw_a_q, raw_b_q, c_a_q, c_b_q, c_qt_q, c_rm_q;
    logic            raw_s_q, c_s_q, c_vld_q;

    assign hit     = c_vld_q && (a_i == c_a_q) && (b_i == c_b_q) && (sgn == c_s_q);
    assign hit_res = op_i[1] ? c_rm_q : c_qt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            raw_a_q <= '0;
            raw_b_q <= '0;
            raw_s_q <= 1'b0;
            c_a_q   <= '0;
            c_b_q   <= '0;
            c_s_q   <= 1'b0;
            c_qt_q  <= '0;
            c_rm_q  <= '0;
            c_vld_q <= 1'b0;
        end else if (load) begin
            raw_a_q <= a_i;
            raw_b_q <= b_i;
            raw_s_q <= sgn;
            if (div0 || ovf) begin
                c_a_q   <= a_i;
                c_b_q   <= b_i;
                c_s_q   <= sgn;
                c_qt_q  <= spec_q;
                c_rm_q  <= spec_r;
                c_vld_q <= 1'b1;
            end
        end else if (fix) begin
            c_a_q   <= raw_a_q;
            c_b_q   <= raw_b_q;
            c_s_q   <= raw_s_q;
            c_qt_q  <= fix_q;
            c_rm_q  <= fix_r;
            c_vld_q <= 1'b1;
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_res = '0;
`endif

    divider_cp #(
        .XLEN(XLEN)
    ) u_cp (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .short_i (short_req),
        .load_o  (load),
        .calc_o  (calc),
        .fix_o   (fix),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    assign result_o = res_q;

endmodule

// File: tb/tb_divider_rv32m.sv
// Directed bench for divider_rv32m: results, latency, busy/done shape, ignored starts, reset abort, optional reuse.
module tb_divider_rv32m;

    localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;
    localparam int FULL = 34;
`ifdef DIV_RESULT_REUSE_EN
    localparam int HIT = 1;
`else
    localparam int HIT = FULL;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'b00;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        busy_o, done_o;
    logic [31:0] result_o;

    int asserts = 0;
    int fails = 0;
    int edges;
    logic busy_ok;

    divider_rv32m dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .start_i  (start_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .busy_o   (busy_o),
        .done_o   (done_o),
        .result_o (result_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        asserts++;
        assert (got === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Drive a request before edge E0; returns just after E0 with edges = 1
    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        op_i = op; a_i = a; b_i = b; start_i = 1'b1;
        @(posedge clk_i);
        edges = 1;
        #1;
        start_i = 1'b0;
        busy_ok = 1'b1;
    endtask

    task automatic wait_done();
        while (done_o !== 1'b1 && edges < 200) begin
            if (busy_o !== 1'b1) busy_ok = 1'b0;
            @(posedge clk_i);
            edges++;
            #1;
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int exp_edges);
        launch(op, a, b);
        wait_done();
        check({tag, " result"}, result_o, exp);
        check({tag, " latency"}, 32'(edges), 32'(exp_edges));
        check({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        @(posedge clk_i);
        #1;
        check({tag, " done pulse"}, {31'd0, done_o}, 32'd0);
        check({tag, " result held"}, result_o, exp);
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        check("reset busy", {31'd0, busy_o}, 32'd0);
        check("reset done", {31'd0, done_o}, 32'd0);
        check("reset result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        do_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd14, FULL);
        do_op("remu 100/7", REMU, 32'd100, 32'd7, 32'd2, HIT);

        do_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, FULL);
        do_op("rem -7/2", REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, HIT);
        do_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, FULL);
        do_op("rem 7/-2", REM, 32'd7, 32'hFFFF_FFFE, 32'd1, HIT);

        do_op("divu 5/0", DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
        do_op("rem -5/0", REM, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);

        do_op("div ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        do_op("rem ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
        do_op("divu ovf ops", DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, FULL);

        // A second start during CALC must be dropped
        launch(DIVU, 32'd1000, 32'd3);
        repeat (4) begin
            @(posedge clk_i);
            edges++;
        end
        @(negedge clk_i);
        op_i = DIVU; a_i = 32'd50; b_i = 32'd5; start_i = 1'b1;
        @(posedge clk_i);
        edges++;
        #1;
        start_i = 1'b0;
        wait_done();
        check("ignored start result", result_o, 32'd333);
        check("ignored start latency", 32'(edges), 32'(FULL));

        // Reset in the middle of an operation aborts it at once
        launch(DIVU, 32'd2000, 32'd3);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("abort busy", {31'd0, busy_o}, 32'd0);
        check("abort done", {31'd0, done_o}, 32'd0);
        check("abort result", result_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        do_op("divu 9/4", DIVU, 32'd9, 32'd4, 32'd2, FULL);

        // Reuse across a reset must be lost
        do_op("div 100/7", DIV, 32'd100, 32'd7, 32'd14, FULL);
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        do_op("rem 100/7 after reset", REM, 32'd100, 32'd7, 32'd2, FULL);

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
